uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer between the UART serial engine and the host/register interface. It captures every byte the receiver strobes out, together with its framing-error flag, into a first-word-fall-through FIFO. The host drains it through a valid/ready handshake. The block reports fill level and almost-full, and holds a sticky overrun flag when the receiver delivers a byte while the buffer is full.

## Interface
Parameters:
- DATA_W, 8, payload width per entry
- DEPTH, 16, number of entries; power of two, ≥ 2
- AFULL_LEVEL, 12, almost_full asserts when level ≥ this value; range 1..DEPTH

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- wr_valid  in  1  one-cycle strobe from the receiver: new byte present
- wr_data  in  DATA_W  received byte
- wr_frame_err  in  1  stop bit was sampled low for this byte
- rd_valid  out  1  FIFO non-empty; head entry is on rd_data/rd_frame_err
- rd_ready  in  1  host accepts the head entry
- rd_data  out  DATA_W  head byte; 0 when rd_valid=0
- rd_frame_err  out  1  head entry's error flag; 0 when rd_valid=0
- level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- almost_full  out  1  level ≥ AFULL_LEVEL
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- clr_overrun  in  1  clears overrun
- flush  in  1  synchronous empty of the FIFO

## Operation
- Storage: DEPTH × (DATA_W+1) register array. Write and read pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. The extra MSB distinguishes full from empty.
- empty = (wptr == rptr). full = addresses equal and MSBs differ. level = wptr − rptr (modulo arithmetic, full width).
- Push: wr_valid && !full writes {wr_frame_err, wr_data} at wptr[AW-1:0], then wptr++.
- Pop: rd_valid && rd_ready increments rptr.
- Write while full: the byte is discarded and overrun is set. This holds even if a pop occurs in the same cycle, because full is evaluated on the pre-edge state.
- Simultaneous push and pop when neither full nor empty: both take effect and level is unchanged.
- When empty, rd_valid=0, so a pop cannot occur.
- overrun: set on a dropped write, cleared by clr_overrun. If both happen in the same cycle, set wins.
- flush: rptr ← wptr (both effectively 0 relative). A push in the same cycle is discarded. overrun is unaffected and storage contents are not cleared.
- No state machine beyond the pointers. All outputs derive from the pointers, the array and the overrun register.

## Timing
- Reset (async assert, sync deassert from the system reset tree): wptr=rptr=0 and overrun=0. Therefore rd_valid=0, rd_data=0, rd_frame_err=0, level=0, almost_full=0.
- Write-to-read latency: a byte strobed on edge N is visible with rd_valid=1 after edge N (one cycle).
- rd_data, rd_frame_err and rd_valid are combinational from the registered pointers and array. They must not depend combinationally on rd_ready.
- After a pop at edge N, the next entry (or rd_valid=0) appears after edge N.
- level, almost_full and overrun update on the edge following the causing event.
- Reset mid-operation: all contents are lost and the outputs above go to their reset values immediately on assertion.

## Structure
- The shared package uart_pkg holds:
  - UART_DATA_W = 8
  - the receive-entry layout: frame_err bit above DATA_W data bits
- This block imports DATA_W's default from that package.
- One sub-module is natural: uart_fifo_mem (parameterised register array with a write port and an asynchronous read port). Pointer, flag and overrun logic stay in uart_rx_fifo.

## Test plan
- Reset, then push 0x55, 0xA3 (frame_err=1), 0x00 on three consecutive cycles with rd_ready=0 → level=3; rd_data=0x55 with rd_frame_err=0.
- Then hold rd_ready=1 → pops return 0x55/0, 0xA3/1, 0x00/0 in order, then rd_valid=0 and rd_data=0.
- Push 16 bytes 0x10..0x1F (DEPTH=16), then push 0xEE → level=16; almost_full=1 from level 12 onward; overrun=1; 0xEE never appears.
- Drain all 16 → data 0x10..0x1F in order.
- Full FIFO, push 0x77 and pop in the same cycle → 0x77 dropped, overrun=1, level=15.
- Next push 0x77 → accepted, level=16, and it is the last entry read.
- Half-full FIFO, sustain push+pop every cycle for 40 cycles (forcing pointer wrap) → level constant, output order matches input order, no overrun.
- Flush with 5 entries and overrun=1, plus a simultaneous push → level=0, rd_valid=0, overrun stays 1.
- clr_overrun coincident with a dropped write → overrun stays 1.
- Assert reset mid-stream with 7 entries → rd_valid, level, almost_full and overrun go to 0 immediately.
- After release, push 0x3C → rd_data=0x3C after one edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: payload width and the layout of one receive entry.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // One receive entry: framing-error flag sits directly above the data bits.
  typedef struct packed {
    logic                   frame_err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

  localparam int UART_RX_ENTRY_W = $bits(uart_rx_entry_t);

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO strobe, host drain handshake and status/control signals.
interface uart_rx_fifo_if #(
  parameter int DATA_W = uart_pkg::UART_DATA_W,
  parameter int DEPTH  = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_err;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_frame_err;
  logic [LW-1:0]     level;
  logic              almost_full;
  logic              overrun;
  logic              clr_overrun;
  logic              flush;

  // Receiver / host side.
  modport master (
    output wr_valid, wr_data, wr_frame_err, rd_ready, clr_overrun, flush,
    input  rd_valid, rd_data, rd_frame_err, level, almost_full, overrun
  );

  // FIFO side.
  modport slave (
    input  wr_valid, wr_data, wr_frame_err, rd_ready, clr_overrun, flush,
    output rd_valid, rd_data, rd_frame_err, level, almost_full, overrun
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Register array with one synchronous write port and an asynchronous read port.
// Contents are deliberately never reset or cleared.
module uart_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Store the incoming entry at the write address.
  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: first-word-fall-through FIFO with level, almost-full
// and a sticky overrun flag for bytes dropped while full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W      = UART_DATA_W,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + 1;

  logic [PW-1:0] wptr_reg, wptr_next;
  logic [PW-1:0] rptr_reg, rptr_next;
  logic          overrun_reg, overrun_next;
  logic          empty, full, push, pop;
  logic [EW-1:0] head;
  logic [PW-1:0] level;

  // Full/empty come from the pre-edge pointers only, so a pop in the same
  // cycle never frees room for a write arriving while full.
  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]) &&
                 (wptr_reg[AW] != rptr_reg[AW]);
  assign push  = bus.wr_valid && !full && !bus.flush;
  assign pop   = !empty && bus.rd_ready;
  assign level = wptr_reg - rptr_reg;

  uart_fifo_mem #(.WIDTH(EW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_reg[AW-1:0]),
    .wdata ({bus.wr_frame_err, bus.wr_data}),
    .raddr (rptr_reg[AW-1:0]),
    .rdata (head)
  );

  // Next pointer and overrun values; flush snaps the read pointer to the
  // write pointer, and a dropped write beats a clear request.
  always_comb begin
    wptr_next    = wptr_reg;
    rptr_next    = rptr_reg;
    overrun_next = overrun_reg;
    if (push) wptr_next = wptr_reg + PW'(1);
    if (bus.flush) rptr_next = wptr_reg;
    else if (pop) rptr_next = rptr_reg + PW'(1);
    if (bus.clr_overrun) overrun_next = 1'b0;
    if (bus.wr_valid && full) overrun_next = 1'b1;
  end

  // Pointer and overrun registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      wptr_reg    <= wptr_next;
      rptr_reg    <= rptr_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.rd_valid     = !empty;
  assign bus.rd_data      = empty ? '0 : head[DATA_W-1:0];
  assign bus.rd_frame_err = empty ? 1'b0 : head[DATA_W];
  assign bus.level        = level;
  assign bus.almost_full  = (level >= PW'(AFULL_LEVEL));
  assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DATA_W=8, DEPTH=16, AFULL_LEVEL=12).
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs settle and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = base + 8'(i);
      bus.wr_frame_err = 1'b0;
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain_seq(input logic [7:0] base, input int n, input string tag);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, {24'd0, bus.rd_data}, {24'd0, base + 8'(i)});
      tick();
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic pop_n(input int n);
    bus.rd_ready = 1'b1;
    repeat (n) tick();
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 0; bus.wr_data = 0; bus.wr_frame_err = 0;
    bus.rd_ready = 0; bus.clr_overrun = 0; bus.flush = 0;
    repeat (2) tick();
    check("reset_rd_valid", {31'd0, bus.rd_valid}, 0);
    check("reset_level", {27'd0, bus.level}, 0);
    check("reset_overrun", {31'd0, bus.overrun}, 0);
    reset = 1'b1;
    tick();

    // Three pushes, no pops.
    bus.wr_valid = 1; bus.wr_data = 8'h55; bus.wr_frame_err = 0; tick();
    bus.wr_data = 8'hA3; bus.wr_frame_err = 1; tick();
    bus.wr_data = 8'h00; bus.wr_frame_err = 0; tick();
    bus.wr_valid = 0;
    check("three_level", {27'd0, bus.level}, 3);
    check("three_head", {24'd0, bus.rd_data}, 32'h55);
    check("three_head_fe", {31'd0, bus.rd_frame_err}, 0);

    // Drain them in order.
    bus.rd_ready = 1;
    check("pop0", {23'd0, bus.rd_frame_err, bus.rd_data}, 32'h055); tick();
    check("pop1", {23'd0, bus.rd_frame_err, bus.rd_data}, 32'h1A3); tick();
    check("pop2", {23'd0, bus.rd_frame_err, bus.rd_data}, 32'h000); tick();
    bus.rd_ready = 0;
    check("empty_valid", {31'd0, bus.rd_valid}, 0);
    check("empty_data", {24'd0, bus.rd_data}, 0);

    // Fill to full with almost_full tracking, then a dropped write.
    for (int i = 0; i < 16; i++) begin
      bus.wr_valid = 1; bus.wr_data = 8'h10 + 8'(i); tick();
      check("fill_afull", {31'd0, bus.almost_full}, (i + 1 >= 12) ? 1 : 0);
    end
    bus.wr_data = 8'hEE; tick();
    bus.wr_valid = 0;
    check("full_level", {27'd0, bus.level}, 16);
    check("full_overrun", {31'd0, bus.overrun}, 1);
    drain_seq(8'h10, 16, "drain_full");
    check("drain_empty", {31'd0, bus.rd_valid}, 0);
    bus.clr_overrun = 1; tick(); bus.clr_overrun = 0;
    check("clr_overrun", {31'd0, bus.overrun}, 0);

    // Push and pop together while full: write dropped.
    push_seq(8'h80, 16);
    bus.wr_valid = 1; bus.wr_data = 8'h77; bus.rd_ready = 1; tick();
    bus.wr_valid = 0; bus.rd_ready = 0;
    check("fullpp_overrun", {31'd0, bus.overrun}, 1);
    check("fullpp_level", {27'd0, bus.level}, 15);
    bus.wr_valid = 1; bus.wr_data = 8'h77; tick(); bus.wr_valid = 0;
    check("refill_level", {27'd0, bus.level}, 16);
    drain_seq(8'h81, 15, "drain_pp");
    check("last_77", {24'd0, bus.rd_data}, 32'h77);
    pop_n(1);
    bus.clr_overrun = 1; tick(); bus.clr_overrun = 0;

    // Half full, sustained push+pop across pointer wrap.
    push_seq(8'h20, 8);
    bus.rd_ready = 1; bus.wr_valid = 1;
    for (int i = 0; i < 40; i++) begin
      bus.wr_data = 8'h40 + 8'(i);
      check("stream", {24'd0, bus.rd_data}, (i < 8) ? 32'h20 + i : 32'h40 + i - 8);
      tick();
    end
    bus.rd_ready = 0; bus.wr_valid = 0;
    check("stream_level", {27'd0, bus.level}, 8);
    check("stream_overrun", {31'd0, bus.overrun}, 0);

    // Flush with 5 entries, overrun set and a coincident push.
    push_seq(8'h90, 8);
    bus.wr_valid = 1; bus.wr_data = 8'hEE; tick(); bus.wr_valid = 0;
    pop_n(11);
    check("preflush_level", {27'd0, bus.level}, 5);
    bus.flush = 1; bus.wr_valid = 1; bus.wr_data = 8'h99; tick();
    bus.flush = 0; bus.wr_valid = 0;
    check("flush_level", {27'd0, bus.level}, 0);
    check("flush_valid", {31'd0, bus.rd_valid}, 0);
    check("flush_overrun", {31'd0, bus.overrun}, 1);

    // Clear coincident with a dropped write: set wins.
    bus.clr_overrun = 1; tick(); bus.clr_overrun = 0;
    check("clr2", {31'd0, bus.overrun}, 0);
    push_seq(8'hA0, 16);
    bus.wr_valid = 1; bus.wr_data = 8'hEE; bus.clr_overrun = 1; tick();
    bus.wr_valid = 0; bus.clr_overrun = 0;
    check("set_wins", {31'd0, bus.overrun}, 1);

    // Reset mid-stream with 7 entries.
    pop_n(9);
    check("prereset_level", {27'd0, bus.level}, 7);
    check("prereset_head", {24'd0, bus.rd_data}, 32'hA9);
    reset = 1'b0;
    #1;
    check("async_valid", {31'd0, bus.rd_valid}, 0);
    check("async_level", {27'd0, bus.level}, 0);
    check("async_afull", {31'd0, bus.almost_full}, 0);
    check("async_overrun", {31'd0, bus.overrun}, 0);
    tick();
    reset = 1'b1;
    tick();
    bus.wr_valid = 1; bus.wr_data = 8'h3C; tick(); bus.wr_valid = 0;
    check("post_valid", {31'd0, bus.rd_valid}, 1);
    check("post_data", {24'd0, bus.rd_data}, 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
